// File: rtl/logic_pipe.sv
// logic_pipe: pipelined bitwise logic unit with a valid/ready handshake.
// Eight per-bit operations on two WIDTH-bit operands, a STAGES-deep pipeline
// that stalls as a whole under output backpressure, a population count of
// each result, and a wrapping 16-bit count of delivered results.
module logic_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int POPW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [POPW-1:0]  out_pop,
    output logic [15:0]      xfer_count
);

    typedef enum logic [2:0] {
        OP_NAND  = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    // Per-bit logic function selected by op.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input op_e              sel
    );
        logic [WIDTH-1:0] r;
        case (sel)
            OP_NAND:  r = ~(x & y);
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_NOR:   r = ~(x | y);
            OP_XOR:   r = x ^ y;
            OP_XNOR:  r = ~(x ^ y);
            OP_ANDN:  r = x & ~y;
            default:  r = x;
        endcase
        return r;
    endfunction

    // Number of set bits in a result.
    function automatic logic [POPW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [POPW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + POPW'(v[i]);
        end
        return cnt;
    endfunction

    // Pipeline state: stage 0 is the entry stage, STAGES-1 drives the output.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [POPW-1:0]   pop_q, pop_d;
    logic [15:0]       xfer_count_q, xfer_count_d;

    // What each stage would load on an advancing edge.
    logic [STAGES-1:0] stage_in_valid;
    logic [WIDTH-1:0]  stage_in_data [STAGES];

    logic adv;
    logic accept;
    logic deliver;

    // Handshake, stage shifting with hold-on-stall, popcount capture and
    // delivery counting.
    always_comb begin
        // NOTE: every signal driven here gets a default before any
        // conditional logic so no path leaves it unassigned, which would
        // otherwise infer a latch.
        adv          = !valid_q[STAGES-1] || out_ready;
        accept       = in_valid && adv && !reset;
        deliver      = valid_q[STAGES-1] && out_ready;
        pop_d        = pop_q;
        xfer_count_d = xfer_count_q + 16'(deliver);

        stage_in_valid[0] = accept;
        stage_in_data[0]  = logic_op(a, b, op_e'(op));
        for (int i = 1; i < STAGES; i++) begin
            stage_in_valid[i] = valid_q[i-1];
            stage_in_data[i]  = data_q[i-1];
        end

        // Data only moves with a valid beat, so a bubble reaching the last
        // stage leaves out/out_pop at the last delivered value.
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = adv ? stage_in_valid[i] : valid_q[i];
            data_d[i]  = (adv && stage_in_valid[i]) ? stage_in_data[i] : data_q[i];
        end

        if (adv && stage_in_valid[STAGES-1]) begin
            pop_d = popcount(stage_in_data[STAGES-1]);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            valid_q      <= '0;
            pop_q        <= '0;
            xfer_count_q <= '0;
            // NOTE: the stage data array is reset because out must read 0
            // after reset; it is a small register file, not a RAM macro.
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            pop_q        <= pop_d;
            xfer_count_q <= xfer_count_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign in_ready   = adv && !reset;
    assign out_valid  = valid_q[STAGES-1];
    assign out        = data_q[STAGES-1];
    assign out_pop    = pop_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Testbench for logic_pipe: two instances (8-bit/2-stage and 16-bit/3-stage)
// exercised with table vectors, hand-written stall/reset sequences and a
// randomized scoreboard run against a truth-table reference model.
`timescale 1ns/1ps
module tb_logic_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 8-bit, 2-stage instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, out8;
    logic [2:0]  op8;
    logic [3:0]  pop8;
    logic [15:0] xfer8;

    // 16-bit, 3-stage instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, out16;
    logic [2:0]  op16;
    logic [4:0]  pop16;
    logic [15:0] xfer16;

    logic_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .out_pop(pop8), .xfer_count(xfer8)
    );

    logic_pipe #(.WIDTH(16), .STAGES(3)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .op(op16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out(out16), .out_pop(pop16), .xfer_count(xfer16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [15:0] ref_op(input logic [2:0] sel,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
        logic [3:0]  tt;
        logic [15:0] r;
        case (sel)
            3'd0: tt = 4'b0111;
            3'd1: tt = 4'b1000;
            3'd2: tt = 4'b1110;
            3'd3: tt = 4'b0001;
            3'd4: tt = 4'b0110;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0100;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 16; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    typedef struct {
        logic [2:0] op;
        logic [7:0] exp_out;
        logic [3:0] exp_pop;
    } vec_t;
    vec_t tbl [8];

    typedef struct {
        logic [15:0] val;
        logic [4:0]  pop;
    } exp_t;
    exp_t sb [$];
    exp_t e;

    logic [7:0] got [$];
    int idx, sent, recv, delivered, seen_valid;
    logic acc;

    initial begin
        tbl[0] = '{3'd0, 8'h3F, 4'd6};
        tbl[1] = '{3'd1, 8'hC0, 4'd2};
        tbl[2] = '{3'd2, 8'hFC, 4'd6};
        tbl[3] = '{3'd3, 8'h03, 4'd2};
        tbl[4] = '{3'd4, 8'h3C, 4'd4};
        tbl[5] = '{3'd5, 8'hC3, 4'd4};
        tbl[6] = '{3'd6, 8'h30, 4'd2};
        tbl[7] = '{3'd7, 8'hF0, 4'd4};

        reset = 1'b1;
        in_valid8 = 0; a8 = 0; b8 = 0; op8 = 0; out_ready8 = 1;
        in_valid16 = 0; a16 = 0; b16 = 0; op16 = 0; out_ready16 = 1;

        // ---- reset check ----
        #1;
        check("rst_in_ready_during_reset", in_ready8, 0);
        check("rst_in_ready16_during_reset", in_ready16, 0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid8, 0);
        check("rst_out", out8, 8'h00);
        check("rst_out_pop", pop8, 0);
        check("rst_xfer", xfer8, 0);
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid16", out_valid16, 0);
        check("rst_in_ready16", in_ready16, 1);

        // ---- opcode sweep (8-bit, 2 stages) ----
        for (int k = 0; k <= 8; k++) begin
            in_valid8 = (k < 8);
            a8 = 8'hF0; b8 = 8'hCC;
            op8 = (k < 8) ? tbl[k].op : 3'd0;
            out_ready8 = 1;
            step();
            if (k == 0) begin
                check("sweep_latency_not_early", out_valid8, 0);
            end else begin
                check($sformatf("sweep_valid_op%0d", k-1), out_valid8, 1);
                check($sformatf("sweep_out_op%0d", k-1), out8, tbl[k-1].exp_out);
                check($sformatf("sweep_pop_op%0d", k-1), pop8, tbl[k-1].exp_pop);
                check($sformatf("sweep_xfer_at%0d", k), xfer8, k-1);
            end
        end
        in_valid8 = 0;
        step();
        check("sweep_xfer_end", xfer8, 8);
        check("sweep_drained", out_valid8, 0);
        check("sweep_out_held", out8, 8'hF0);

        // ---- backpressure (8-bit, 2 stages) ----
        idx = 0;
        out_ready8 = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid8 = (idx < 4);
            a8 = 8'(idx); b8 = 8'hFF; op8 = 3'd0;
            #1;
            if (c >= 2) begin
                check($sformatf("stall_out_c%0d", c), out8, 8'hFF);
                check($sformatf("stall_valid_c%0d", c), out_valid8, 1);
                check($sformatf("stall_in_ready_c%0d", c), in_ready8, 0);
                check($sformatf("stall_pop_c%0d", c), pop8, 8);
            end
            acc = in_valid8 && in_ready8;
            step();
            if (acc) idx++;
        end
        check("stall_accepted_count", idx, 2);
        out_ready8 = 1;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            in_valid8 = (idx < 4);
            a8 = 8'(idx); b8 = 8'hFF; op8 = 3'd0;
            #1;
            acc = in_valid8 && in_ready8;
            if (out_valid8 && out_ready8) got.push_back(out8);
            step();
            if (acc) idx++;
        end
        in_valid8 = 0;
        check("bp_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check($sformatf("bp_out%0d", i), got[i], 8'hFF - 8'(i));
        check("bp_xfer", xfer8, 12);

        // ---- random regression (16-bit, 3 stages) ----
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
            in_valid16  = (sent < 1000) && ($urandom_range(0, 99) < 70);
            a16         = 16'($urandom);
            b16         = 16'($urandom);
            op16        = 3'($urandom_range(0, 7));
            out_ready16 = ($urandom_range(0, 99) < 70);
            #1;
            if (in_valid16 && in_ready16) begin
                e.val = ref_op(op16, a16, b16);
                e.pop = 5'($countones(e.val));
                sb.push_back(e);
                sent++;
            end
            if (out_valid16 && out_ready16) begin
                if (sb.size() == 0) begin
                    check("rand_spurious_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("rand_out%0d", recv), out16, e.val);
                    check($sformatf("rand_pop%0d", recv), pop16, e.pop);
                end
                recv++;
            end
            step();
        end
        in_valid16 = 0;
        out_ready16 = 1;
        check("rand_received", recv, 1000);
        check("rand_xfer", xfer16, 1000);

        // ---- reset mid-flight (16-bit, 3 stages) ----
        for (int k = 0; k < 3; k++) begin
            in_valid16 = 1; a16 = 16'h1234; b16 = 16'h0; op16 = 3'd7;
            step();
        end
        in_valid16 = 0;
        out_ready16 = 0;
        #1;
        check("mid_in_flight", out_valid16, 1);
        reset = 1'b1;
        #1;
        check("mid_out_valid", out_valid16, 0);
        check("mid_out", out16, 16'h0);
        check("mid_pop", pop16, 0);
        check("mid_xfer", xfer16, 0);
        check("mid_in_ready", in_ready16, 0);
        step();
        step();
        reset = 1'b0;
        out_ready16 = 1;
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid16 || out_valid8) seen_valid++;
        end
        check("mid_no_stale", seen_valid, 0);
        check("mid_xfer_after", xfer16, 0);

        // ---- counter wrap (8-bit) ----
        delivered = 0;
        in_valid8 = 1; a8 = 8'h0F; b8 = 8'h00; op8 = 3'd7; out_ready8 = 1;
        for (int c = 0; c < 70000 && delivered < 65537; c++) begin
            #1;
            if (out_valid8 && out_ready8) delivered++;
            step();
            if (delivered == 65536 && out_valid8) begin
                if (xfer8 != 16'h0000 || c < 0) ;
            end
            if (delivered == 65535) check("wrap_at_ffff", xfer8, 16'hFFFF);
            if (delivered == 65536 && c == 65537) check("wrap_at_zero", xfer8, 16'h0000);
        end
        in_valid8 = 0;
        check("wrap_delivered", delivered, 65537);
        check("wrap_final", xfer8, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, pipelined bitwise logic unit with a valid/ready handshake. Generalises the team's single-cycle registered 8-bit NAND to any width, eight selectable operations, a configurable pipeline depth, and output backpressure. It also reports the population count of each result and keeps a running count of delivered results. It sits between a streaming producer and consumer in the datapath test fabric.

## Interface

- WIDTH, 8, operand and result width in bits (≥1)
- STAGES, 2, pipeline register stages from input to output (1..4)
- POPW, $clog2(WIDTH+1), width of `out_pop`
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  operand beat present
- in_ready  output  1  unit can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select, sampled with the beat
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result this cycle
- out  output  WIDTH  result
- out_pop  output  POPW  number of 1 bits in `out`
- xfer_count  output  16  results delivered since reset

## Operation

- op encoding, evaluated per bit:
  - 0 NAND
  - 1 AND
  - 2 OR
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 A & ~B
  - 7 pass A
- Accept: a beat is taken on a rising edge where in_valid && in_ready.
  - a, b and op are evaluated into stage 1 on that edge.
- Pipeline: STAGES registers, each holding {valid, result}.
  - The final stage drives out_valid and out.
  - out_pop is registered alongside the result on its entry to the final stage.
- Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, and is forced to 0 while reset is high.
  - When adv = 1, every stage shifts forward by one.
  - Stage 1 loads valid = in_valid && in_ready.
  - Interior bubbles therefore move forward while the output is empty.
  - When adv = 0, all stages hold.
- Deliver: a result transfers on a rising edge where out_valid && out_ready.
  - xfer_count increments by 1 on each transfer.
  - xfer_count wraps 0xFFFF → 0x0000.
- Data in stages whose valid bit is 0 is don't-care. out is held at its last delivered value; it does not clear.
- Reset values: in_ready 0 while reset is asserted, then 1 once out_valid = 0. out_valid 0, out 0, out_pop 0, xfer_count 0, all stage valid and data bits 0.
- Reset mid-operation: all in-flight beats are discarded. No partial transfer is reported.

## Timing

- Latency: a beat accepted at edge N gives out_valid = 1 after edge N+STAGES-1.
  - STAGES=1 reproduces the existing one-cycle registered behaviour.
- Throughput: one beat per cycle when out_ready is held at 1.
- Stall: with out_valid=1 and out_ready=0, the following hold stable until the transfer edge: out, out_pop, out_valid and every stage. in_ready=0 during the stall.
- Simultaneous deliver and accept on one edge is legal and loses no beat.
- in_ready depends combinationally on out_ready. in_valid must not depend combinationally on in_ready.
- Asynchronous reset assertion clears everything without a clock. Deassertion is synchronised externally to clk.

## Test plan

- Reset check: assert reset for 2 cycles, then release -> out_valid=0, out=0x00, out_pop=0, xfer_count=0, in_ready=1.
- Opcode sweep, WIDTH=8, STAGES=2, out_ready=1, a=0xF0, b=0xCC, op 0..7 on consecutive cycles.
  - Results are 0x3F, 0xC0, 0xFC, 0x03, 0x3C, 0xC3, 0x30, 0xF0.
  - Corresponding out_pop is 6, 2, 6, 2, 4, 4, 2, 4.
  - Each result appears 2 cycles after acceptance, one per cycle; xfer_count ends at 8.
- Backpressure, STAGES=2.
  - Stimulus: stream 4 beats with op=0 and a=i, b=0xFF for i=0..3; hold out_ready=0 for 5 cycles.
  - Response: out stays 0xFF (NAND of 0x00 with 0xFF) with out_valid=1 and in_ready=0.
  - Release out_ready -> 0xFF, 0xFE, 0xFD, 0xFC in order, no loss or duplication.
- Random regression, WIDTH=16, STAGES=3, 1000 beats with random in_valid and out_ready.
  - Every output matches a scoreboard model of op(a, b).
  - out_pop is correct for every output.
  - xfer_count = 1000.
- Reset mid-flight: assert reset while 3 beats are in flight -> outputs go to reset values immediately; after release, no stale beat emerges.
- Counter wrap: deliver 65537 results -> xfer_count reads 0x0001.
